// File: rtl/ripple_count_tracker_pkg.sv
// Shared types and defaults for the ripple counter tracking slice.
package ripple_count_tracker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_ERROR   = 2'd3
    } state_e;

    localparam int unsigned DEF_CNT_W       = 3;
    localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/ripple_count_tracker_sync_chain.sv
// Multi-flop synchronizer for bus signals from the ripple-counter domain.
module ripple_count_tracker_sync_chain #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ripple_count_tracker.sv
// Tracks a synchronized ripple counter, extending it to a wide count with
// wrap strobes, illegal-step detection and roll-over flagging.
module ripple_count_tracker
    import ripple_count_tracker_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned EXT_W       = 8,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned MAX_STEP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [CNT_W-1:0] cnt_in,
    output logic [EXT_W-1:0] count_ext,
    output logic             valid,
    output logic             wrap_pulse,
    output logic             err,
    output logic             ovf
);

    localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);
    localparam logic [FILL_W-1:0] FILL_DONE  = FILL_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0]  MAX_STEP_C = CNT_W'(MAX_STEP);

    logic [CNT_W-1:0] s_val;

    ripple_count_tracker_sync_chain #(
        .WIDTH (CNT_W),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (cnt_in),
        .q_o    (s_val)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] last_val_q, last_val_d;
    logic [EXT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    logic [CNT_W-1:0] delta;
    logic             is_wrap;
    logic [EXT_W:0]   sum;
    logic             fill_done;

    assign delta     = s_val - last_val_q;
    assign is_wrap   = (delta != '0) && (s_val < last_val_q);
    assign sum       = {1'b0, count_q} + {{(EXT_W + 1 - CNT_W){1'b0}}, delta};
    // Acquisition after reset waits until the synchronizer holds real samples.
    assign fill_done = (fill_q == FILL_DONE);
    assign fill_d    = fill_done ? fill_q : fill_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        last_val_d = last_val_q;
        count_d    = count_q;
        valid_d    = valid_q;
        wrap_d     = 1'b0;
        err_d      = err_q;
        ovf_d      = ovf_q;
        if (clear) begin
            state_d = en ? ST_ACQUIRE : ST_IDLE;
            count_d = '0;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    valid_d = 1'b0;
                    if (en && fill_done) state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    last_val_d = s_val;
                    count_d    = EXT_W'(s_val);
                    err_d      = 1'b0;
                    ovf_d      = 1'b0;
                    valid_d    = 1'b1;
                    state_d    = ST_TRACK;
                end
                ST_TRACK: begin
                    if (!en) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end else if (delta != '0) begin
                        if (delta <= MAX_STEP_C) begin
                            last_val_d = s_val;
                            count_d    = sum[EXT_W-1:0];
                            wrap_d     = is_wrap;
                            if (sum[EXT_W]) ovf_d = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            valid_d = 1'b0;
                            state_d = ST_ERROR;
                        end
                    end
                end
                ST_ERROR: begin
                    valid_d = 1'b0;
                    if (!en) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            last_val_q <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_val_q <= last_val_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            fill_q     <= fill_d;
        end
    end

    assign count_ext  = count_q;
    assign valid      = valid_q;
    assign wrap_pulse = wrap_q;
    assign err        = err_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_ripple_count_tracker.sv
// Directed vector bench for ripple_count_tracker (EXT_W=4 to reach roll-over quickly).
module tb_ripple_count_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] cnt_in = '0;
    logic [3:0] count_ext;
    logic       valid, wrap_pulse, err, ovf;

    int checks = 0;
    int errors = 0;

    ripple_count_tracker #(
        .CNT_W       (3),
        .EXT_W       (4),
        .SYNC_STAGES (2),
        .MAX_STEP    (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .clear      (clear),
        .cnt_in     (cnt_in),
        .count_ext  (count_ext),
        .valid      (valid),
        .wrap_pulse (wrap_pulse),
        .err        (err),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         en;
        bit         clr;
        logic [2:0] cnt;
        logic [3:0] ce;
        bit         va;
        bit         wr;
        bit         er;
        bit         ov;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input bit e, input bit c, input int cn, input int ce,
                                input bit va, input bit wr, input bit er, input bit ov);
        vec_t r;
        r.en = e; r.clr = c; r.cnt = 3'(cn); r.ce = 4'(ce);
        r.va = va; r.wr = wr; r.er = er; r.ov = ov;
        return r;
    endfunction

    task automatic check(input string name, input logic [3:0] ce, input bit va,
                         input bit wr, input bit er, input bit ov);
        logic [7:0] act, exp;
        act = {count_ext, valid, wrap_pulse, err, ovf};
        exp = {ce, va, wr, er, ov};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got count_ext=%0d valid=%b wrap=%b err=%b ovf=%b, want count_ext=%0d valid=%b wrap=%b err=%b ovf=%b",
                     name, count_ext, valid, wrap_pulse, err, ovf, ce, va, wr, er, ov);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        en = v.en; clear = v.clr; cnt_in = v.cnt;
        @(posedge clk);
        #1;
        check(name, v.ce, v.va, v.wr, v.er, v.ov);
    endtask

    task automatic reset_seq(input string tag);
        reset = 1'b0; en = 1'b1; clear = 1'b0; cnt_in = 3'd5;
        repeat (2) @(posedge clk);
        #1;
        check({tag, " reset hold"}, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s release edge%0d", tag, k), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1;
        check({tag, " acquired"}, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        bit wr_e;

        // flush pipeline at 0 via clear, then count 0..7,0,1
        vq.push_back(mk(1,1,0, 0,0,0,0,0));
        vq.push_back(mk(1,1,0, 0,0,0,0,0));
        vq.push_back(mk(1,0,0, 0,1,0,0,0));
        vq.push_back(mk(1,0,1, 0,1,0,0,0));
        vq.push_back(mk(1,0,2, 0,1,0,0,0));
        vq.push_back(mk(1,0,3, 1,1,0,0,0));
        vq.push_back(mk(1,0,4, 2,1,0,0,0));
        vq.push_back(mk(1,0,5, 3,1,0,0,0));
        vq.push_back(mk(1,0,6, 4,1,0,0,0));
        vq.push_back(mk(1,0,7, 5,1,0,0,0));
        vq.push_back(mk(1,0,0, 6,1,0,0,0));
        vq.push_back(mk(1,0,1, 7,1,0,0,0));
        vq.push_back(mk(1,0,1, 8,1,1,0,0));
        vq.push_back(mk(1,0,1, 9,1,0,0,0));
        vq.push_back(mk(1,0,1, 9,1,0,0,0));
        // illegal jump 2 -> 5, then clear with en
        vq.push_back(mk(1,0,2, 9,1,0,0,0));
        vq.push_back(mk(1,0,5, 9,1,0,0,0));
        vq.push_back(mk(1,0,5, 10,1,0,0,0));
        vq.push_back(mk(1,0,5, 10,0,0,1,0));
        vq.push_back(mk(1,0,5, 10,0,0,1,0));
        vq.push_back(mk(1,1,5, 0,0,0,0,0));
        vq.push_back(mk(1,0,5, 5,1,0,0,0));
        // enable drop at 6 while counter advances to 3
        vq.push_back(mk(1,0,6, 5,1,0,0,0));
        vq.push_back(mk(1,0,6, 5,1,0,0,0));
        vq.push_back(mk(1,0,6, 6,1,0,0,0));
        vq.push_back(mk(0,0,7, 6,0,0,0,0));
        vq.push_back(mk(0,0,0, 6,0,0,0,0));
        vq.push_back(mk(0,0,1, 6,0,0,0,0));
        vq.push_back(mk(0,0,2, 6,0,0,0,0));
        vq.push_back(mk(0,0,3, 6,0,0,0,0));
        vq.push_back(mk(0,0,3, 6,0,0,0,0));
        vq.push_back(mk(0,0,3, 6,0,0,0,0));
        vq.push_back(mk(1,0,3, 6,0,0,0,0));
        vq.push_back(mk(1,0,3, 3,1,0,0,0));

        reset_seq("init");

        for (int i = 0; i < vq.size(); i++) begin
            apply($sformatf("vec%0d", i), vq[i]);
        end

        // roll-over: 16 steps from 0 on a 4-bit extended count
        apply("roll clr1", mk(1,1,0, 0,0,0,0,0));
        apply("roll clr2", mk(1,1,0, 0,0,0,0,0));
        apply("roll acq",  mk(1,0,0, 0,1,0,0,0));
        for (int i = 1; i <= 20; i++) begin
            n = (i < 2) ? 0 : i - 2;
            if (n > 16) n = 16;
            wr_e = (i <= 18) && (n > 0) && (n % 8 == 0);
            apply($sformatf("roll step%0d", i),
                  mk(1, 0, (i <= 16) ? i % 8 : 0, n % 16, 1, wr_e, 0, n >= 16));
        end
        apply("ovf sticky", mk(1,0,1, 0,1,0,0,1));
        apply("ovf clr1",   mk(1,1,0, 0,0,0,0,0));
        apply("ovf clr2",   mk(1,1,0, 0,0,0,0,0));
        apply("ovf acq",    mk(1,0,0, 0,1,0,0,0));

        // advance to 5, then assert reset between edges
        apply("pre1", mk(1,0,1, 0,1,0,0,0));
        apply("pre2", mk(1,0,2, 0,1,0,0,0));
        apply("pre3", mk(1,0,3, 1,1,0,0,0));
        apply("pre4", mk(1,0,4, 2,1,0,0,0));
        apply("pre5", mk(1,0,5, 3,1,0,0,0));
        apply("pre6", mk(1,0,5, 4,1,0,0,0));
        apply("pre7", mk(1,0,5, 5,1,0,0,0));
        #3;
        reset = 1'b0;
        #1;
        check("async reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_seq("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
